mul_share_arbiter_taint: RTL and testbench
==========================================

# mul_share_arbiter_taint

Round-robin arbiter and sequencer that shares one bitwise-taint-tracked sequential multiplier among NREQ requesters. It accepts operand pairs over a valid/ready handshake, issues one start pulse to the multiplier control, waits for productDone, and returns the product to the granted requester. Every control and data output carries a bitwise taint shadow (`_t`) under conservative propagation rules. It sits between client blocks and the multiplier datapath/control pair.

## Interface
- WIDTH, 4, operand width; product is 2*WIDTH
- NREQ, 2, number of requesters (2..4)
- IDXW, $clog2(NREQ), grant index width (derived)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid / req_valid_t  in  NREQ  per-requester request and taint
- req_a / req_a_t  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b / req_b_t  in  NREQ*WIDTH  operand B, same packing
- req_ready / req_ready_t  out  NREQ  one-hot accept pulse and taint
- resp_valid / resp_valid_t  out  NREQ  one-hot result pulse and taint
- resp_product / resp_product_t  out  2*WIDTH  result and taint
- mul_start / mul_start_t  out  1  start pulse to multiplier control
- mul_a / mul_a_t, mul_b / mul_b_t  out  WIDTH  operands to datapath
- mul_done / mul_done_t  in  1  productDone from multiplier control
- mul_product / mul_product_t  in  2*WIDTH  datapath product

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: scan req_valid starting at rr_ptr, wrapping modulo NREQ. The first set bit is grant g.
  - Same cycle: req_ready[g]=1.
  - Latch g, req_a[g], and req_b[g] into op regs; go to ISSUE; rr_ptr <= (g+1) mod NREQ.
  - No request: stay in IDLE; rr_ptr unchanged.
- ISSUE: mul_start=1 for exactly this cycle → WAIT.
- WAIT: hold. On mul_done=1, latch mul_product → RESP.
- RESP: resp_valid[g]=1 for one cycle → IDLE. No grant is made in the RESP cycle.
- mul_a/mul_b are driven from the op regs continuously. They are stable from ISSUE until the next grant.
- resp_product holds its last latched value until the next WAIT→RESP transition.
- mul_done in IDLE, ISSUE or RESP is ignored.
- Taint rules:
  - grant_t = OR of all req_valid_t in IDLE, because any tainted valid can alter the choice.
  - req_ready_t[i] = grant_t for all i when any grant occurs; otherwise 0.
  - At grant:
    - state_t <= grant_t.
    - op_a_t <= req_a_t[g] | {WIDTH{grant_t}}; op_b_t is formed the same way.
  - IDLE with no request: state_t <= grant_t, since the decision to wait is itself tainted.
  - WAIT: state_t <= state_t | mul_done_t. On the transition, prod_t <= mul_product_t | {2W{state_t|mul_done_t}}.
  - mul_start_t = state_t in ISSUE; otherwise 0.
  - resp_valid_t[i] = state_t for all i in RESP; otherwise 0.
  - resp_product_t = prod_t.
  - mul_a_t/mul_b_t = op regs' taint.
- Taint is never cleared mid-transaction. It is recomputed only at the IDLE decision.

## Timing
- Reset values:
  - State IDLE, rr_ptr=0, g=0.
  - All op, product and taint registers are 0.
  - Every output is 0: req_ready, resp_valid, mul_start, mul_a/b, resp_product and all `_t`.
- Latency:
  - Grant at cycle T, mul_start at T+1.
  - mul_done at cycle D → resp_valid at D+1.
  - Minimum back-to-back grant spacing is 4 cycles (IDLE, ISSUE, WAIT≥1, RESP).
- Handshake:
  - A requester must hold valid and operands until it sees ready.
  - Dropping valid before ready withdraws the request without error.
- Simultaneous requests: the grant goes to the first valid at or after rr_ptr. The ptr wraps from NREQ-1 to 0.
- Synchronous reset in any state:
  - Next cycle is IDLE with all outputs 0.
  - The in-flight transaction is dropped; no resp_valid is produced.
  - rst overrides a same-cycle mul_done.

## Test plan
- Single request, WIDTH=4:
  - Stimulus: req0 a=3, b=5, no taint.
  - Required: ready0 pulses once; mul_start pulses the next cycle; after mul_done with product 15, resp_valid[0]=1 and resp_product=8'd15; all `_t`=0.
- Contention:
  - Stimulus: req0 and req1 both valid from reset.
  - Required: grants go 0, then 1, then 0; each result routes to the correct resp_valid bit.
- Taint on operand only:
  - Stimulus: req1 with req_a_t=4'b0010.
  - Required: mul_a_t=4'b0010 and mul_b_t=0; mul_start_t=0; resp_valid_t=0.
- Taint on valid:
  - Stimulus: req_valid_t[0]=1 while req1 is granted.
  - Required: req_ready_t=2'b11; mul_start_t=1; mul_a_t and mul_b_t all ones; resp_valid_t=2'b11; resp_product_t all ones.
- Spurious and tainted done:
  - Stimulus: mul_done pulsed in IDLE and ISSUE.
  - Required: it is ignored.
  - Stimulus: mul_done_t=1 in WAIT.
  - Required: resp_product_t=8'hFF.
- Reset mid-WAIT:
  - Stimulus: rst asserted for 1 cycle.
  - Required: state returns to IDLE; no resp_valid; rr_ptr=0; all outputs and taint are 0 the next cycle.

Source files
------------

// File: rtl/mul_share_arbiter_taint_if.sv
// Bundle of requester-side and multiplier-side signals for the shared
// multiplier arbiter. Every signal has a bitwise taint shadow (_t).
interface mul_share_arbiter_taint_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
);
    // requester side
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_valid_t;
    logic [NREQ*WIDTH-1:0]  req_a;
    logic [NREQ*WIDTH-1:0]  req_a_t;
    logic [NREQ*WIDTH-1:0]  req_b;
    logic [NREQ*WIDTH-1:0]  req_b_t;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_ready_t;
    logic [NREQ-1:0]        resp_valid;
    logic [NREQ-1:0]        resp_valid_t;
    logic [2*WIDTH-1:0]     resp_product;
    logic [2*WIDTH-1:0]     resp_product_t;

    // multiplier side
    logic                   mul_start;
    logic                   mul_start_t;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_a_t;
    logic [WIDTH-1:0]       mul_b;
    logic [WIDTH-1:0]       mul_b_t;
    logic                   mul_done;
    logic                   mul_done_t;
    logic [2*WIDTH-1:0]     mul_product;
    logic [2*WIDTH-1:0]     mul_product_t;

    // arbiter view
    modport slave (
        input  req_valid, req_valid_t, req_a, req_a_t, req_b, req_b_t,
        output req_ready, req_ready_t, resp_valid, resp_valid_t,
        output resp_product, resp_product_t,
        output mul_start, mul_start_t, mul_a, mul_a_t, mul_b, mul_b_t,
        input  mul_done, mul_done_t, mul_product, mul_product_t
    );

    // clients + multiplier view
    modport master (
        output req_valid, req_valid_t, req_a, req_a_t, req_b, req_b_t,
        input  req_ready, req_ready_t, resp_valid, resp_valid_t,
        input  resp_product, resp_product_t,
        input  mul_start, mul_start_t, mul_a, mul_a_t, mul_b, mul_b_t,
        output mul_done, mul_done_t, mul_product, mul_product_t
    );
endinterface

// File: rtl/mul_share_arbiter_taint.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier among
// NREQ requesters, with conservative bitwise taint tracking on all outputs.
module mul_share_arbiter_taint #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2,
    parameter int IDXW  = $clog2(NREQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    mul_share_arbiter_taint_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                 state_q;
    state_e                 state_d;

    logic [IDXW-1:0]        rr_ptr_q;
    logic [IDXW-1:0]        g_q;
    logic                   state_t_q;
    logic [WIDTH-1:0]       op_a_q;
    logic [WIDTH-1:0]       op_b_q;
    logic [WIDTH-1:0]       op_a_t_q;
    logic [WIDTH-1:0]       op_b_t_q;
    logic [2*WIDTH-1:0]     prod_q;
    logic [2*WIDTH-1:0]     prod_t_q;

    logic                   found_s;
    logic                   grant_s;
    logic                   grant_t_s;
    logic [IDXW-1:0]        grant_idx_s;
    logic [IDXW-1:0]        rr_next_s;

    // Convert a requester index into its one-hot select vector.
    function automatic logic [NREQ-1:0] idx_onehot(input logic [IDXW-1:0] idx);
        idx_onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        logic take;
        found_s     = 1'b0;
        grant_idx_s = {IDXW{1'b0}};
        idx         = 0;
        take        = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx         = (int'(rr_ptr_q) + k) % NREQ;
            take        = !found_s && bus.req_valid[idx];
            grant_idx_s = take ? IDXW'(idx) : grant_idx_s;
            found_s     = found_s | bus.req_valid[idx];
        end
        // A grant only happens in IDLE and never during a reset cycle.
        grant_s   = found_s && (state_q == IDLE) && !rst;
        // Any tainted valid could have changed the arbitration outcome.
        grant_t_s = (state_q == IDLE) ? (|bus.req_valid_t) : 1'b0;
        rr_next_s = (grant_idx_s == IDXW'(NREQ - 1)) ? {IDXW{1'b0}}
                                                     : grant_idx_s + IDXW'(1);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mul_done outside WAIT has no effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant_s ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = bus.mul_done ? RESP : WAIT;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: ready in IDLE on grant, start in ISSUE, result in RESP.
    always_comb begin
        bus.req_ready    = {NREQ{1'b0}};
        bus.req_ready_t  = {NREQ{1'b0}};
        bus.resp_valid   = {NREQ{1'b0}};
        bus.resp_valid_t = {NREQ{1'b0}};
        bus.mul_start    = 1'b0;
        bus.mul_start_t  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    bus.req_ready   = idx_onehot(grant_idx_s);
                    bus.req_ready_t = {NREQ{grant_t_s}};
                end else begin
                    bus.req_ready   = {NREQ{1'b0}};
                    bus.req_ready_t = {NREQ{1'b0}};
                end
            end
            ISSUE: begin
                bus.mul_start   = 1'b1;
                bus.mul_start_t = state_t_q;
            end
            WAIT: begin
                bus.mul_start   = 1'b0;
            end
            RESP: begin
                bus.resp_valid   = idx_onehot(g_q);
                bus.resp_valid_t = {NREQ{state_t_q}};
            end
            default: begin
                bus.mul_start   = 1'b0;
            end
        endcase
    end

    // Operand, product, pointer and taint registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= {IDXW{1'b0}};
            g_q       <= {IDXW{1'b0}};
            state_t_q <= 1'b0;
            op_a_q    <= {WIDTH{1'b0}};
            op_b_q    <= {WIDTH{1'b0}};
            op_a_t_q  <= {WIDTH{1'b0}};
            op_b_t_q  <= {WIDTH{1'b0}};
            prod_q    <= {(2*WIDTH){1'b0}};
            prod_t_q  <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    // Taint of the decision itself, granted or not.
                    state_t_q <= grant_t_s;
                    if (grant_s) begin
                        g_q      <= grant_idx_s;
                        rr_ptr_q <= rr_next_s;
                        op_a_q   <= bus.req_a[int'(grant_idx_s)*WIDTH +: WIDTH];
                        op_b_q   <= bus.req_b[int'(grant_idx_s)*WIDTH +: WIDTH];
                        op_a_t_q <= bus.req_a_t[int'(grant_idx_s)*WIDTH +: WIDTH]
                                    | {WIDTH{grant_t_s}};
                        op_b_t_q <= bus.req_b_t[int'(grant_idx_s)*WIDTH +: WIDTH]
                                    | {WIDTH{grant_t_s}};
                    end
                end
                WAIT: begin
                    // A tainted done could have changed when we leave WAIT.
                    state_t_q <= state_t_q | bus.mul_done_t;
                    if (bus.mul_done) begin
                        prod_q   <= bus.mul_product;
                        prod_t_q <= bus.mul_product_t
                                    | {(2*WIDTH){state_t_q | bus.mul_done_t}};
                    end
                end
                default: begin
                    state_t_q <= state_t_q;
                end
            endcase
        end
    end

    // Operands and result are presented straight from their registers.
    assign bus.mul_a          = op_a_q;
    assign bus.mul_b          = op_b_q;
    assign bus.mul_a_t        = op_a_t_q;
    assign bus.mul_b_t        = op_b_t_q;
    assign bus.resp_product   = prod_q;
    assign bus.resp_product_t = prod_t_q;

endmodule

// File: tb/tb_mul_share_arbiter_taint.sv
// Scoreboard bench for mul_share_arbiter_taint (WIDTH=4, NREQ=2). The bench
// plays both the requesters and the multiplier control/datapath.
module tb_mul_share_arbiter_taint;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mul_share_arbiter_taint_if #(.WIDTH(4), .NREQ(2)) bus ();

    mul_share_arbiter_taint #(.WIDTH(4), .NREQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         idx;
        logic [7:0] prod;
        logic [7:0] prod_t;
        logic [1:0] rv_t;
    } exp_t;

    exp_t sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs driven and outputs sampled 2 time units after the edge
    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs;
        bus.req_valid     = 2'b00;
        bus.req_valid_t   = 2'b00;
        bus.req_a         = 8'h00;
        bus.req_a_t       = 8'h00;
        bus.req_b         = 8'h00;
        bus.req_b_t       = 8'h00;
        bus.mul_done      = 1'b0;
        bus.mul_done_t    = 1'b0;
        bus.mul_product   = 8'h00;
        bus.mul_product_t = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".req_ready"},      bus.req_ready,      2'b00);
        check_val({tag, ".req_ready_t"},    bus.req_ready_t,    2'b00);
        check_val({tag, ".resp_valid"},     bus.resp_valid,     2'b00);
        check_val({tag, ".resp_valid_t"},   bus.resp_valid_t,   2'b00);
        check_val({tag, ".mul_start"},      bus.mul_start,      1'b0);
        check_val({tag, ".mul_start_t"},    bus.mul_start_t,    1'b0);
        check_val({tag, ".mul_a"},          bus.mul_a,          4'h0);
        check_val({tag, ".mul_a_t"},        bus.mul_a_t,        4'h0);
        check_val({tag, ".mul_b"},          bus.mul_b,          4'h0);
        check_val({tag, ".mul_b_t"},        bus.mul_b_t,        4'h0);
        check_val({tag, ".resp_product"},   bus.resp_product,   8'h00);
        check_val({tag, ".resp_product_t"}, bus.resp_product_t, 8'h00);
    endtask

    // One full transaction from the IDLE decision through RESP back to IDLE.
    task automatic run_txn(input string tag, input int exp_idx,
                           input logic [1:0] vld, input logic [1:0] vld_t,
                           input logic [7:0] a, input logic [7:0] a_t,
                           input logic [7:0] b, input logic [7:0] b_t,
                           input logic done_t, input logic spur, input int wait_n);
        logic       gt;
        logic [1:0] oh;
        logic [3:0] ea, eb, eat, ebt;
        exp_t       e;
        exp_t       got;
        gt  = |vld_t;
        oh  = 2'b01 << exp_idx;
        ea  = a[exp_idx*4 +: 4];
        eb  = b[exp_idx*4 +: 4];
        eat = a_t[exp_idx*4 +: 4] | {4{gt}};
        ebt = b_t[exp_idx*4 +: 4] | {4{gt}};

        bus.req_valid   = vld;
        bus.req_valid_t = vld_t;
        bus.req_a       = a;
        bus.req_a_t     = a_t;
        bus.req_b       = b;
        bus.req_b_t     = b_t;
        #1;
        check_val({tag, ".req_ready"},   bus.req_ready,   oh);
        check_val({tag, ".req_ready_t"}, bus.req_ready_t, {2{gt}});
        e.idx    = exp_idx;
        e.prod   = {4'd0, ea} * {4'd0, eb};
        e.prod_t = {8{gt | done_t}};
        e.rv_t   = {2{gt | done_t}};
        sb_q.push_back(e);

        step;  // ISSUE
        bus.req_valid   = vld & ~oh;
        bus.mul_done    = spur;
        bus.mul_product = 8'hAA;
        #1;
        check_val({tag, ".mul_start"},   bus.mul_start,   1'b1);
        check_val({tag, ".mul_start_t"}, bus.mul_start_t, gt);
        check_val({tag, ".mul_a"},       bus.mul_a,       ea);
        check_val({tag, ".mul_b"},       bus.mul_b,       eb);
        check_val({tag, ".mul_a_t"},     bus.mul_a_t,     eat);
        check_val({tag, ".mul_b_t"},     bus.mul_b_t,     ebt);
        check_val({tag, ".ready_issue"}, bus.req_ready,   2'b00);

        step;  // WAIT
        bus.mul_done = 1'b0;
        for (int k = 0; k < wait_n; k++) begin
            #1;
            check_val({tag, ".wait_start"}, bus.mul_start,  1'b0);
            check_val({tag, ".wait_resp"},  bus.resp_valid, 2'b00);
            step;
        end
        // multiplier model answers from the operands it is being fed
        bus.mul_done    = 1'b1;
        bus.mul_done_t  = done_t;
        bus.mul_product = {4'd0, bus.mul_a} * {4'd0, bus.mul_b};
        step;  // RESP
        bus.mul_done    = 1'b0;
        bus.mul_done_t  = 1'b0;
        bus.mul_product = 8'h00;
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check_val({tag, ".resp_valid"},     bus.resp_valid,     2'b01 << got.idx);
            check_val({tag, ".resp_valid_t"},   bus.resp_valid_t,   got.rv_t);
            check_val({tag, ".resp_product"},   bus.resp_product,   got.prod);
            check_val({tag, ".resp_product_t"}, bus.resp_product_t, got.prod_t);
        end
        step;  // back to IDLE
        bus.req_valid = 2'b00;
        #1;
        check_val({tag, ".resp_once"}, bus.resp_valid, 2'b00);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step;
        step;
        rst = 1'b0;
        #1;
        check_all_zero("reset");

        // single request: 3 * 5 = 15, no taint
        run_txn("single", 0, 2'b01, 2'b00, 8'h03, 8'h00, 8'h05, 8'h00, 1'b0, 1'b0, 1);

        // spurious done while IDLE is ignored
        bus.mul_done    = 1'b1;
        bus.mul_product = 8'h77;
        step;
        bus.mul_done    = 1'b0;
        bus.mul_product = 8'h00;
        #1;
        check_val("idle_done.start", bus.mul_start,  1'b0);
        check_val("idle_done.resp",  bus.resp_valid, 2'b00);
        step;
        check_val("idle_done.resp2", bus.resp_valid,   2'b00);
        check_val("idle_done.prod",  bus.resp_product, 8'd15);

        // contention from reset: grants 0, 1, 0
        rst = 1'b1;
        step;
        rst = 1'b0;
        #1;
        check_val("rst2.prod", bus.resp_product, 8'h00);
        run_txn("cont0", 0, 2'b11, 2'b00, 8'h72, 8'h00, 8'h69, 8'h00, 1'b0, 1'b0, 1);
        run_txn("cont1", 1, 2'b11, 2'b00, 8'h72, 8'h00, 8'h69, 8'h00, 1'b0, 1'b0, 2);
        run_txn("cont2", 0, 2'b11, 2'b00, 8'h4D, 8'h00, 8'hEB, 8'h00, 1'b0, 1'b0, 1);

        // operand taint only on requester 1 operand A
        run_txn("op_taint", 1, 2'b10, 2'b00, 8'h93, 8'h20, 8'h50, 8'h00, 1'b0, 1'b0, 1);

        // tainted valid on requester 0 while requester 1 is granted
        run_txn("vld_taint", 1, 2'b10, 2'b01, 8'hB0, 8'h00, 8'hC0, 8'h00, 1'b0, 1'b0, 1);

        // spurious done in ISSUE plus tainted done in WAIT
        run_txn("done_taint", 0, 2'b01, 2'b00, 8'h0E, 8'h00, 8'h0D, 8'h00, 1'b1, 1'b1, 3);

        // reset mid-WAIT with a same-cycle mul_done (rr_ptr is 1 here)
        bus.req_valid   = 2'b01;
        bus.req_valid_t = 2'b01;
        bus.req_a       = 8'h09;
        bus.req_b       = 8'h07;
        #1;
        check_val("midwait.grant", bus.req_ready, 2'b01);
        step;  // ISSUE
        clear_inputs();
        step;  // WAIT
        step;  // WAIT
        rst             = 1'b1;
        bus.mul_done    = 1'b1;
        bus.mul_done_t  = 1'b1;
        bus.mul_product = 8'h55;
        step;
        rst = 1'b0;
        clear_inputs();
        #1;
        check_all_zero("midwait");
        step;
        check_val("midwait.noresp", bus.resp_valid, 2'b00);

        // pointer restarted at 0 so requester 0 wins contention
        run_txn("post_rst", 0, 2'b11, 2'b00, 8'h23, 8'h00, 8'h44, 8'h00, 1'b0, 1'b0, 1);

        check_val("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // hard stop in case the flow ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
